// File: rtl/mod_fetch_ctrl_pkg.sv
// fetch_ctrl_pkg -- shared types for the fetch controller.
//   XLEN / PC_RESET_ADDR : overridable macros, defaults below.
//   fsm_e   : controller states.
//   src_e   : redirect sources, encoded in ascending priority so that
//             a plain >= compare gives "may overwrite".
//   redir_t : one redirect {valid, src, target}.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h0000_1000
`endif

package fetch_ctrl_pkg;
   localparam int unsigned XLEN = `XLEN;
   localparam logic [XLEN-1:0] PC_RESET = `PC_RESET_ADDR;

   typedef enum logic [1:0] {BOOT, RUN, REDIR, HALT} fsm_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      JMP  = 2'd1,
      BR   = 2'd2,
      TRAP = 2'd3
   } src_e;

   typedef struct packed {
      logic            valid;
      src_e            src;
      logic [XLEN-1:0] target;
   } redir_t;
endpackage

// File: rtl/mod_fetch_ctrl_if.sv
// mod_fetch_ctrl_if -- instruction-memory fetch handshake.
//   imem_req_o  : fetch request (controller -> memory)
//   imem_addr_o : fetch address, held stable until granted
//   imem_gnt_i  : grant; a transfer completes when req & gnt
interface mod_fetch_ctrl_if;
   import fetch_ctrl_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;

   modport master (output imem_req_o, output imem_addr_o, input imem_gnt_i);
   modport slave  (input imem_req_o, input imem_addr_o, output imem_gnt_i);
endinterface

// File: rtl/mod_fetch_ctrl_redirect_arb.sv
// mod_redirect_arb -- combinational fixed-priority pick among the
// same-cycle redirect strobes (trap > br > jmp).
//   *_stb_i / *_pc_i : redirect strobes and targets
//   win_o            : winning redirect, valid=0 when no strobe
module mod_redirect_arb
   import fetch_ctrl_pkg::*;
(
   input  logic            trap_stb_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            br_stb_i,
   input  logic [XLEN-1:0] br_pc_i,
   input  logic            jmp_stb_i,
   input  logic [XLEN-1:0] jmp_pc_i,
   output redir_t          win_o
);
   always_comb begin
      win_o = '{valid: 1'b0, src: NONE, target: '0};
      if (trap_stb_i)     win_o = '{valid: 1'b1, src: TRAP, target: trap_pc_i};
      else if (br_stb_i)  win_o = '{valid: 1'b1, src: BR,   target: br_pc_i};
      else if (jmp_stb_i) win_o = '{valid: 1'b1, src: JMP,  target: jmp_pc_i};
   end
endmodule

// File: rtl/mod_fetch_ctrl.sv
// mod_fetch_ctrl -- instruction fetch controller (BOOT/RUN/REDIR/HALT).
//   clk_i, rst_ni        : clock, async active-low reset
//   stall_i              : pipeline backpressure
//   trap/br/jmp_stb_i,_pc_i : redirect strobes + targets
//   halt_i               : halt-fetch level
//   pc_cur_i             : current PC from mod_pc
//   pc_o/pc_stb_o/pc_stall_o : load/stall controls to mod_pc
//   imem                 : fetch handshake (master side)
//   flush_o              : kill wrong-path instruction in IF/ID
//   misalign_o           : misaligned-target fault pulse
// Optional feature: define PC_MISALIGN_TRAP_EN to fault on targets with
// bits[1:0] != 0 instead of silently aligning them.
module mod_fetch_ctrl
   import fetch_ctrl_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            stall_i,
   input  logic            trap_stb_i,
   input  logic [XLEN-1:0] trap_pc_i,
   input  logic            br_stb_i,
   input  logic [XLEN-1:0] br_pc_i,
   input  logic            jmp_stb_i,
   input  logic [XLEN-1:0] jmp_pc_i,
   input  logic            halt_i,
   input  logic [XLEN-1:0] pc_cur_i,
   output logic [XLEN-1:0] pc_o,
   output logic            pc_stb_o,
   output logic            pc_stall_o,
   mod_fetch_ctrl_if.master imem,
   output logic            flush_o,
   output logic            misalign_o
);
   fsm_e            state_q, state_d;
   redir_t          pend_q, pend_d, pend_clr, win;
   logic            hold_q, hold_d;   // request issued and not yet granted
   logic [XLEN-1:0] addr_q, addr_d;
   logic            req, take, tgt_bad;
   logic [XLEN-1:0] addr, tgt;

   // While halted only a trap may be captured.
   mod_redirect_arb u_arb (
      .trap_stb_i (trap_stb_i),
      .trap_pc_i  (trap_pc_i),
      .br_stb_i   (br_stb_i  & (state_q != HALT)),
      .br_pc_i    (br_pc_i),
      .jmp_stb_i  (jmp_stb_i & (state_q != HALT)),
      .jmp_pc_i   (jmp_pc_i),
      .win_o      (win)
   );

`ifdef PC_MISALIGN_TRAP_EN
   assign tgt     = pend_q.target;
   assign tgt_bad = |pend_q.target[1:0];
`else
   assign tgt     = pend_q.target & ~XLEN'(3);
   assign tgt_bad = 1'b0;
`endif

   // Pending register: REDIR consumes it first, so a strobe arriving in
   // the same cycle lands in an empty slot and triggers another REDIR.
   always_comb begin
      pend_clr = pend_q;
      if (state_q == REDIR) pend_clr.valid = 1'b0;
      take   = win.valid & (~pend_clr.valid | (win.src >= pend_clr.src));
      pend_d = take ? win : pend_clr;
      hold_d = req & ~imem.imem_gnt_i;
      addr_d = addr;
   end

   // Next state and outputs. Leaving RUN waits until no request is left
   // ungranted, so the address hold can never be broken by a redirect.
   always_comb begin
      state_d    = state_q;
      req        = 1'b0;
      addr       = hold_q ? addr_q : pc_cur_i;
      pc_o       = PC_RESET;
      pc_stb_o   = 1'b0;
      flush_o    = 1'b0;
      misalign_o = 1'b0;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            req = hold_q | ~stall_i;
            if (!(req && !imem.imem_gnt_i)) begin
               if (pend_d.valid) state_d = REDIR;
               else if (halt_i)  state_d = HALT;
            end
         end
         REDIR: begin
            pc_o       = tgt;
            pc_stb_o   = ~tgt_bad;
            flush_o    = 1'b1;
            misalign_o = tgt_bad;
            if (pend_d.valid) state_d = REDIR;
            else if (halt_i)  state_d = HALT;
            else              state_d = RUN;
         end
         HALT: if (pend_d.valid) state_d = REDIR;
         default: state_d = BOOT;
      endcase
   end

   assign imem.imem_req_o  = req;
   assign imem.imem_addr_o = addr;
   assign pc_stall_o = stall_i | (req & ~imem.imem_gnt_i) | (state_q != RUN);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BOOT;
         pend_q  <= '0;
         hold_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         hold_q  <= hold_d;
         addr_q  <= addr_d;
      end
   end
endmodule

// File: tb/tb_mod_fetch_ctrl.sv
// tb_mod_fetch_ctrl -- directed + randomized bench with a behavioural
// reference model and a simple mod_pc environment model.
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h0000_1000
`endif

module tb_mod_fetch_ctrl;
   localparam logic [31:0] RST_PC = `PC_RESET_ADDR;
`ifdef PC_MISALIGN_TRAP_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        stall_i, trap_stb_i, br_stb_i, jmp_stb_i, halt_i;
   logic [31:0] trap_pc_i, br_pc_i, jmp_pc_i, pc_cur_i, pc_o;
   logic        pc_stb_o, pc_stall_o, flush_o, misalign_o;

   mod_fetch_ctrl_if imem_bus ();

   mod_fetch_ctrl dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .stall_i    (stall_i),
      .trap_stb_i (trap_stb_i),
      .trap_pc_i  (trap_pc_i),
      .br_stb_i   (br_stb_i),
      .br_pc_i    (br_pc_i),
      .jmp_stb_i  (jmp_stb_i),
      .jmp_pc_i   (jmp_pc_i),
      .halt_i     (halt_i),
      .pc_cur_i   (pc_cur_i),
      .pc_o       (pc_o),
      .pc_stb_o   (pc_stb_o),
      .pc_stall_o (pc_stall_o),
      .imem       (imem_bus),
      .flush_o    (flush_o),
      .misalign_o (misalign_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;

   // Model: fetching / applying a redirect / halted / just out of reset,
   // a single pending redirect (rank 3=trap,2=br,1=jmp), an ungranted fetch.
   bit          m_boot, m_apply, m_halt, m_pv, m_ov;
   int          m_prank;
   logic [31:0] m_ptgt, m_oaddr, pc_env;
   logic        e_req, e_stb, e_flush, e_mis, e_stall;
   logic [31:0] e_pc, e_addr;
   int          halt_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_boot = 1; m_apply = 0; m_halt = 0; m_pv = 0; m_ov = 0;
      m_prank = 0; m_ptgt = '0; m_oaddr = '0;
      pc_env = RST_PC; pc_cur_i = RST_PC;
   endtask

   task automatic idle();
      stall_i = 0; halt_i = 0;
      trap_stb_i = 0; br_stb_i = 0; jmp_stb_i = 0;
      trap_pc_i = '0; br_pc_i = '0; jmp_pc_i = '0;
      imem_bus.imem_gnt_i = 1'b1;
   endtask

   function automatic void predict();
      bit fetching, bad;
      fetching = !m_boot && !m_apply && !m_halt;
      e_req = 0; e_stb = 0; e_flush = 0; e_mis = 0;
      e_pc = RST_PC; e_addr = pc_env;
      if (fetching) begin
         e_req  = m_ov || !stall_i;
         e_addr = m_ov ? m_oaddr : pc_env;
      end
      if (m_apply) begin
         bad     = MIS_EN && (m_ptgt[1:0] != 2'b00);
         e_pc    = MIS_EN ? m_ptgt : {m_ptgt[31:2], 2'b00};
         e_stb   = !bad;
         e_flush = 1;
         e_mis   = bad;
      end
      e_stall = stall_i || (e_req && !imem_bus.imem_gnt_i) || !fetching;
   endfunction

   // Per-cycle comparison against the model, at the falling edge.
   task automatic sample();
      @(negedge clk_i);
      predict();
      chkb("req", imem_bus.imem_req_o, e_req);
      if (e_req) chk("addr", imem_bus.imem_addr_o, e_addr);
      chkb("pc_stb", pc_stb_o, e_stb);
      chkb("flush", flush_o, e_flush);
      chkb("misalign", misalign_o, e_mis);
      chkb("pc_stall", pc_stall_o, e_stall);
      if (e_stb || !rst_ni) chk("pc_o", pc_o, e_pc);
   endtask

   // Evolve the model across the next rising edge (inputs already stable).
   task automatic advance();
      bit          fetching, ungnt, n_pv, n_apply, n_halt;
      int          wr, n_prank;
      logic [31:0] wt, n_ptgt, n_pc;
      fetching = !m_boot && !m_apply && !m_halt;
      wr = 0; wt = '0;
      if (trap_stb_i)                 begin wr = 3; wt = trap_pc_i; end
      else if (br_stb_i  && !m_halt)  begin wr = 2; wt = br_pc_i;   end
      else if (jmp_stb_i && !m_halt)  begin wr = 1; wt = jmp_pc_i;  end
      n_pv = m_pv && !m_apply; n_prank = m_prank; n_ptgt = m_ptgt;
      if (wr != 0 && (!n_pv || wr >= n_prank)) begin
         n_pv = 1; n_prank = wr; n_ptgt = wt;
      end
      ungnt = e_req && !imem_bus.imem_gnt_i;
      n_apply = 0; n_halt = 0;
      if (m_boot) begin
         n_apply = 0;
      end else if (fetching) begin
         if (!ungnt) begin
            if (n_pv) n_apply = 1;
            else if (halt_i) n_halt = 1;
         end
      end else if (m_apply) begin
         if (n_pv) n_apply = 1;
         else if (halt_i) n_halt = 1;
      end else begin
         n_apply = n_pv; n_halt = !n_pv;
      end
      n_pc = e_stb ? e_pc : (!e_stall ? pc_env + 32'd4 : pc_env);
      @(posedge clk_i);
      if (rst_ni) begin
         m_boot = 0; m_apply = n_apply; m_halt = n_halt;
         m_pv = n_pv; m_prank = n_prank; m_ptgt = n_ptgt;
         m_ov = ungnt; m_oaddr = e_addr;
         pc_env = n_pc;
      end
      #1;
      pc_cur_i = pc_env;
   endtask

   function automatic logic [31:0] rnd_tgt();
      logic [31:0] t;
      t = $urandom & 32'h0000_fffc;
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      return t;
   endfunction

   initial begin
      logic [31:0] a0;
      idle();
      rst_ni = 0;
      model_reset();

      // reset values
      sample();
      chkb("rst_req", imem_bus.imem_req_o, 1'b0);
      chk("rst_pc", pc_o, RST_PC);
      chkb("rst_stb", pc_stb_o, 1'b0);
      chkb("rst_flush", flush_o, 1'b0);
      chkb("rst_mis", misalign_o, 1'b0);
      advance();
      sample();
      advance();
      rst_ni = 1;

      // boot cycle then sequential fetch with gnt tied high
      sample();
      chkb("boot_no_req", imem_bus.imem_req_o, 1'b0);
      advance();
      for (int i = 0; i < 3; i++) begin
         sample();
         chkb("seq_req", imem_bus.imem_req_o, 1'b1);
         chk("seq_addr", imem_bus.imem_addr_o, RST_PC + 32'(4 * i));
         advance();
      end

      // br + jmp in the same cycle: br wins, jmp dropped
      br_stb_i = 1; br_pc_i = 32'h100; jmp_stb_i = 1; jmp_pc_i = 32'h200;
      sample(); advance();
      br_stb_i = 0; jmp_stb_i = 0;
      sample();
      chkb("brj_stb", pc_stb_o, 1'b1);
      chk("brj_pc", pc_o, 32'h100);
      chkb("brj_flush", flush_o, 1'b1);
      chkb("brj_req", imem_bus.imem_req_o, 1'b0);
      advance();
      sample();
      chkb("brj_once", pc_stb_o, 1'b0);
      chk("brj_next_addr", imem_bus.imem_addr_o, 32'h100);
      advance();

      // branch while a request sits ungranted for three cycles
      imem_bus.imem_gnt_i = 1'b0;
      br_stb_i = 1; br_pc_i = 32'h300;
      a0 = pc_env;
      sample();
      chkb("hold_req0", imem_bus.imem_req_o, 1'b1);
      chk("hold_addr0", imem_bus.imem_addr_o, a0);
      advance();
      br_stb_i = 0;
      for (int i = 0; i < 2; i++) begin
         sample();
         chk("hold_addr", imem_bus.imem_addr_o, a0);
         chkb("hold_no_stb", pc_stb_o, 1'b0);
         advance();
      end
      imem_bus.imem_gnt_i = 1'b1;
      sample();
      chk("hold_gnt_addr", imem_bus.imem_addr_o, a0);
      advance();
      sample();
      chkb("hold_redir_stb", pc_stb_o, 1'b1);
      chk("hold_redir_pc", pc_o, 32'h300);
      advance();

      // halt, trap out of halt (br ignored while halted), resume
      halt_i = 1;
      sample(); advance();
      sample();
      chkb("halt_req", imem_bus.imem_req_o, 1'b0);
      chkb("halt_stall", pc_stall_o, 1'b1);
      advance();
      trap_stb_i = 1; trap_pc_i = 32'h80; br_stb_i = 1; br_pc_i = 32'h444;
      sample(); advance();
      trap_stb_i = 0; br_stb_i = 0; halt_i = 0;
      sample();
      chkb("trap_stb", pc_stb_o, 1'b1);
      chk("trap_pc", pc_o, 32'h80);
      advance();
      sample();
      chkb("resume_req", imem_bus.imem_req_o, 1'b1);
      chk("resume_addr", imem_bus.imem_addr_o, 32'h80);
      advance();

      // misaligned branch target
      br_stb_i = 1; br_pc_i = 32'h102;
      sample(); advance();
      br_stb_i = 0;
      sample();
      if (MIS_EN) begin
         chkb("mis_pulse", misalign_o, 1'b1);
         chkb("mis_no_stb", pc_stb_o, 1'b0);
         chkb("mis_flush", flush_o, 1'b1);
      end else begin
         chkb("align_stb", pc_stb_o, 1'b1);
         chk("align_pc", pc_o, 32'h100);
         chkb("align_no_mis", misalign_o, 1'b0);
      end
      advance();

      // randomized traffic
      for (int n = 0; n < 1500; n++) begin
         stall_i = ($urandom_range(0, 3) == 0);
         imem_bus.imem_gnt_i = ($urandom_range(0, 2) != 0);
         trap_stb_i = ($urandom_range(0, 29) == 0); trap_pc_i = rnd_tgt();
         br_stb_i   = ($urandom_range(0, 9) == 0);  br_pc_i   = rnd_tgt();
         jmp_stb_i  = ($urandom_range(0, 9) == 0);  jmp_pc_i  = rnd_tgt();
         if (halt_cnt > 0) begin
            halt_cnt--; halt_i = 1;
         end else begin
            halt_i = 0;
            if ($urandom_range(0, 49) == 0) halt_cnt = $urandom_range(1, 20);
         end
         sample(); advance();
      end

      // get back to fetching, then drop reset mid-handshake
      idle();
      trap_stb_i = 1; trap_pc_i = 32'h500;
      sample(); advance();
      trap_stb_i = 0;
      for (int i = 0; i < 3; i++) begin sample(); advance(); end
      imem_bus.imem_gnt_i = 1'b0;
      sample(); advance();
      sample();
      chkb("mid_req", imem_bus.imem_req_o, 1'b1);
      #2;
      rst_ni = 0;
      model_reset();
      #1;
      chkb("async_rst_req", imem_bus.imem_req_o, 1'b0);
      chkb("async_rst_stb", pc_stb_o, 1'b0);
      advance();
      sample(); advance();
      rst_ni = 1;
      imem_bus.imem_gnt_i = 1'b1;
      sample();
      chkb("reboot_no_req", imem_bus.imem_req_o, 1'b0);
      advance();
      sample();
      chk("reboot_addr", imem_bus.imem_addr_o, RST_PC);
      advance();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mod_fetch_ctrl.md
MOD_FETCH_CTRL -- requirements
Module: mod_fetch_ctrl

Interface
REQ-001 SHALL have clk_i  in  1  system clock, rising-edge.
REQ-002 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have stall_i  in  1  pipeline backpressure.
REQ-004 SHALL have trap_stb_i / trap_pc_i  in  1 / `XLEN  trap redirect strobe and target.
REQ-005 SHALL have br_stb_i / br_pc_i  in  1 / `XLEN  taken-branch redirect from EX.
REQ-006 SHALL have jmp_stb_i / jmp_pc_i  in  1 / `XLEN  jump redirect from ID.
REQ-007 SHALL have halt_i  in  1  halt-fetch request, level.
REQ-008 SHALL have pc_cur_i  in  `XLEN  current PC from mod_pc.
REQ-009 SHALL have pc_o / pc_stb_o / pc_stall_o  out  `XLEN / 1 / 1  drive mod_pc pc_i / pc_stb_i / stall_i.
REQ-010 SHALL have imem_req_o / imem_addr_o  out  1 / `XLEN  fetch request and address.
REQ-011 SHALL have imem_gnt_i  in  1  fetch grant; transfer completes when req and gnt are both high.
REQ-012 SHALL have flush_o  out  1  kill wrong-path instruction in IF/ID.
REQ-013 SHALL have misalign_o  out  1  misaligned-target fault pulse.

Function
REQ-014 SHALL implement FSM states BOOT, RUN, REDIR, HALT.
REQ-015 SHALL select among same-cycle redirect strobes with fixed priority trap > br > jmp.
REQ-016 SHALL hold one pending-redirect register (valid, target, source); new winner overwrites pending only if its priority >= pending source priority.
REQ-017 SHALL capture redirects in every state; in HALT, only trap is captured.
REQ-018 SHALL keep imem_req_o high and imem_addr_o stable once asserted until the grant cycle, regardless of stall_i, redirects or halt_i.
REQ-019 SHALL drive imem_addr_o = pc_cur_i when a request launches.
REQ-020 SHALL drive pc_stall_o = stall_i | (imem_req_o & ~imem_gnt_i) | (state != RUN).
REQ-021 SHALL move BOOT -> RUN one cycle after reset release, with no request in BOOT.
REQ-022 In RUN, SHALL assert imem_req_o when ~stall_i, or while holding an ungranted request.
REQ-023 RUN -> REDIR SHALL occur when pending is valid and no ungranted request exists; a redirect-to-apply latency of 1 cycle is the minimum.
REQ-024 In REDIR, SHALL assert for exactly one cycle pc_stb_o=1, pc_o=pending target and flush_o=1, with imem_req_o=0; pending is cleared.
REQ-025 A redirect strobed during REDIR SHALL be captured into pending after the clear, so the next state is REDIR again.
REQ-026 REDIR SHALL go to HALT if halt_i, else to RUN.
REQ-027 RUN -> HALT SHALL occur when halt_i, no pending and no ungranted request.
REQ-028 HALT SHALL leave only via a captured trap (-> REDIR); imem_req_o=0 in HALT.

Reset
REQ-029 Reset assertion SHALL immediately force state=BOOT, pending invalid, and pc_stb_o, imem_req_o, flush_o, misalign_o = 0, pc_o = `PC_RESET_ADDR; this also aborts any in-flight handshake.
REQ-030 All state SHALL be flopped on clk_i rising edge and rst_ni falling edge.

Configuration
REQ-031 With PC_MISALIGN_TRAP_EN defined, a pending target with bits[1:0] != 0 SHALL NOT be applied in REDIR: pc_stb_o=0, flush_o=1, misalign_o=1 for one cycle, pending cleared.
REQ-032 Without PC_MISALIGN_TRAP_EN, target bits[1:0] SHALL be forced to 0 and misalign_o tied 0.

Structure
REQ-033 fetch_ctrl_pkg SHALL hold the FSM state enum, the redirect-source enum (NONE, JMP, BR, TRAP, ordered by priority) and the redirect struct {valid, src, target}.
REQ-034 Priority selection SHALL live in sub-module mod_redirect_arb (combinational, three requests -> one redirect struct).

Verification
REQ-035 Reset release with gnt tied high -> BOOT for 1 cycle, then imem_addr_o = `PC_RESET_ADDR, `PC_RESET_ADDR+4, ... each cycle.
REQ-036 br_stb_i and jmp_stb_i in the same cycle (0x100/0x200) -> one REDIR cycle with pc_o=0x100 and flush_o=1; jmp dropped.
REQ-037 br_stb_i to 0x300 while a request is ungranted for 3 cycles -> imem_addr_o stable; REDIR occurs the cycle after the grant.
REQ-038 halt_i high -> HALT with req=0 and pc_stall_o=1; trap_stb_i to 0x80 -> REDIR with pc_o=0x80; halt_i low afterwards -> RUN.
REQ-039 br to 0x102 with PC_MISALIGN_TRAP_EN -> misalign_o=1, pc_stb_o=0; without the macro -> pc_o=0x100.
REQ-040 rst_ni dropped mid-handshake -> imem_req_o=0 in the same cycle without waiting for a clock edge.
